// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single data memory.
// Each access takes three cycles: grant (IDLE), memory command (ACCESS), and
// completion pulse (RESP). Misaligned or out-of-range accesses are rejected.
// A rejected access never reaches the memory, but it keeps the same timing.
module dm_arbiter #(
    parameter int unsigned ADDR_LIMIT = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  wbits0,
    input  logic [2:0]  rbits0,
    output logic        gnt0,
    output logic        done0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  wbits1,
    input  logic [2:0]  rbits1,
    output logic        gnt1,
    output logic        done1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        MemR,
    output logic        MemWr,
    output logic [1:0]  MemWrBits,
    output logic [2:0]  MemRBits,
    output logic [31:0] addr,
    output logic [31:0] data,
    input  logic [31:0] ReadData
);

    // MemR_* load codes shared with the data memory (lbu/lb need no alignment check)
    localparam logic [2:0] MEMR_LW  = 3'd0;
    localparam logic [2:0] MEMR_LHU = 3'd1;
    localparam logic [2:0] MEMR_LH  = 3'd2;
    localparam logic [1:0] WB_SW    = 2'b00;
    localparam logic [1:0] WB_SH    = 2'b01;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        last_grant;
    logic        cur_port;
    logic        l_wr;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  l_wbits;
    logic [2:0]  l_rbits;
    logic        any_req;
    logic        win;
    logic        is_word;
    logic        is_half;
    logic        acc_err;

    // Round-robin pick: a lone request wins; on a tie the port not granted last wins
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) win = ~last_grant;
        else              win = req1;
    end

    // Reject misaligned word/halfword accesses and anything beyond the address bound
    always_comb begin
        is_word = l_wr ? (l_wbits == WB_SW) : (l_rbits == MEMR_LW);
        is_half = l_wr ? (l_wbits == WB_SH) : ((l_rbits == MEMR_LHU) || (l_rbits == MEMR_LH));
        acc_err = (is_word && (l_addr[1:0] != 2'b00)) ||
                  (is_half && l_addr[0]) ||
                  (l_addr >= ADDR_LIMIT);
    end

    // Next-state and all combinational outputs; memory command only exists in ACCESS
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        MemR       = 1'b0;
        MemWr      = 1'b0;
        MemWrBits  = 2'b00;
        MemRBits   = 3'b000;
        addr       = 32'h0;
        data       = 32'h0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                    gnt0       = ~win;
                    gnt1       = win;
                end
            end
            ACCESS: begin
                state_next = RESP;
                MemWr      = l_wr & ~acc_err;
                MemR       = ~l_wr & ~acc_err;
                MemWrBits  = l_wbits;
                MemRBits   = l_rbits;
                addr       = l_addr;
                data       = l_wdata;
            end
            RESP: begin
                state_next = IDLE;
                done0      = ~cur_port;
                done1      = cur_port;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Latch the winning request and remember it for the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            l_wr       <= 1'b0;
            l_addr     <= 32'h0;
            l_wdata    <= 32'h0;
            l_wbits    <= 2'b00;
            l_rbits    <= 3'b000;
        end else if (state == IDLE && any_req) begin
            last_grant <= win;
            cur_port   <= win;
            l_wr       <= win ? wr1    : wr0;
            l_addr     <= win ? addr1  : addr0;
            l_wdata    <= win ? wdata1 : wdata0;
            l_wbits    <= win ? wbits1 : wbits0;
            l_rbits    <= win ? rbits1 : rbits0;
        end
    end

    // Capture the result at the end of ACCESS so it is stable when done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= 32'h0;
            rdata1 <= 32'h0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else if (state == ACCESS) begin
            if (!cur_port) begin
                err0 <= acc_err;
                if (acc_err)   rdata0 <= 32'h0;
                else if (!l_wr) rdata0 <= ReadData;
            end else begin
                err1 <= acc_err;
                if (acc_err)   rdata1 <= 32'h0;
                else if (!l_wr) rdata1 <= ReadData;
            end
        end
    end

endmodule
